// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared encodings for the integer execution units.
//   alu_op_e   : ALU operation encoding
//   md_op_e    : multiply/divide operation encoding (op_i of muldiv_unit)
//   md_state_e : muldiv_unit FSM state encoding
//   helpers classifying an md_op_e by operand signedness and op family
package muldiv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU});
  endfunction

  function automatic logic op_is_rem(input md_op_e op);
    return (op inside {MD_REM, MD_REMU});
  endfunction

  // rs1 is treated as two's complement for these ops
  function automatic logic op_a_signed(input md_op_e op);
    return (op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic op_b_signed(input md_op_e op);
    return (op inside {MD_MULH, MD_DIV, MD_REM});
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/result handshake bundle of muldiv_unit.
//   Request : valid_i, ready_o, op_i, a_i, b_i, flush_i
//   Result  : valid_o, ready_i, res_o, busy_o
//   master = requester/consumer side, slave = muldiv_unit side.
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_i;
  logic                  ready_o;
  logic [2:0]            op_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  flush_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] res_o;
  logic                  busy_o;

  modport master (
    output valid_i, op_i, a_i, b_i, flush_i, ready_i,
    input  ready_o, valid_o, res_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, flush_i, ready_i,
    output ready_o, valid_o, res_o, busy_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter -- combinational iteration step retiring BITS_PER_CYCLE bits.
//   is_div  : 1 = restoring divide, 0 = shift-add multiply
//   hi, lo  : accumulator pair (multiply: product hi/lo, divide: remainder/quotient)
//   opnd    : multiplicand magnitude or divisor magnitude
//   hi_next, lo_next : accumulator pair after the step
module muldiv_iter #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] opnd,
  output logic [DATA_WIDTH-1:0] hi_next,
  output logic [DATA_WIDTH-1:0] lo_next
);
  localparam int W = DATA_WIDTH;

  logic [W-1:0] h;
  logic [W-1:0] l;
  logic [W:0]   rs;
  logic [W:0]   sum;

  // unrolled chain of single-bit multiply or divide steps
  always_comb begin
    h   = hi;
    l   = lo;
    rs  = {(W+1){1'b0}};
    sum = {(W+1){1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        // shift next dividend bit into the partial remainder; the extra
        // top bit lets the compare see values up to twice the divisor
        rs = {h, l[W-1]};
        l  = {l[W-2:0], 1'b0};
        if (rs >= {1'b0, opnd}) begin
          h    = rs[W-1:0] - opnd;
          l[0] = 1'b1;
        end else begin
          h = rs[W-1:0];
        end
      end else begin
        // add multiplicand when the current multiplier bit is set, then
        // shift the whole {carry, hi, lo} right by one
        sum = l[0] ? ({1'b0, h} + {1'b0, opnd}) : {1'b0, h};
        l   = {sum[0], l[W-1:1]};
        h   = sum[W:1];
      end
    end
    hi_next = h;
    lo_next = l;
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV-style MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : muldiv_unit_if slave (request in, result out, flush, busy)
// Operands are captured as magnitudes plus a negate flag; the core iterates
// DATA_WIDTH/BITS_PER_CYCLE steps, then one final cycle applies the sign and
// registers the result. Divide-by-zero and signed overflow are preloaded so
// that the final cycle runs immediately after acceptance.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  muldiv_unit_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int PW = DATA_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_STEP = CW'(BITS_PER_CYCLE);
  localparam logic [W-1:0]  ZERO     = {W{1'b0}};
  localparam logic [W-1:0]  ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [PW-1:0] ONE_P    = {{(PW-1){1'b0}}, 1'b1};

  md_state_e     state, state_next;
  md_op_e        op_q, op_in;
  logic          neg_q, neg_ld, sa, sb;
  logic [CW-1:0] cnt, cnt_ld;
  logic [W-1:0]  hi, lo, opnd, res;
  logic [W-1:0]  hi_ld, lo_ld, opnd_ld, a_mag, b_mag;
  logic [W-1:0]  hi_nx, lo_nx, quo_fix, rem_fix, result_c;
  logic [PW-1:0] prod, prod_fix;
  logic          accept, step, finish, drop;

  muldiv_iter #(.DATA_WIDTH(W), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_iter (
    .is_div  (op_is_div(op_q)),
    .hi      (hi),
    .lo      (lo),
    .opnd    (opnd),
    .hi_next (hi_nx),
    .lo_next (lo_nx)
  );

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and datapath control; flush beats ready_i, ignored in IDLE
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.valid_i) begin
          accept     = 1'b1;
          state_next = ST_CALC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (bus.flush_i) begin
          drop       = 1'b1;
          state_next = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end else begin
          step       = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_DONE: begin
        if (bus.flush_i || bus.ready_i) begin
          drop       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: begin
        drop       = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  // operand preparation at acceptance: magnitudes, negate flag, corner cases
  always_comb begin
    op_in = md_op_e'(bus.op_i);
    sa    = op_a_signed(op_in) & bus.a_i[W-1];
    sb    = op_b_signed(op_in) & bus.b_i[W-1];
    a_mag = sa ? (~bus.a_i + ONE) : bus.a_i;
    b_mag = sb ? (~bus.b_i + ONE) : bus.b_i;
    if (op_is_div(op_in)) begin
      if (bus.b_i == ZERO) begin
        // quotient all ones, remainder = dividend, no iteration
        hi_ld   = bus.a_i;
        lo_ld   = ALL_ONES;
        opnd_ld = ZERO;
        neg_ld  = 1'b0;
        cnt_ld  = CNT_LAST;
      end else if ((op_in inside {MD_DIV, MD_REM}) &&
                   (bus.a_i == MOST_NEG) && (bus.b_i == ALL_ONES)) begin
        // signed overflow: quotient = most-negative, remainder = 0
        hi_ld   = ZERO;
        lo_ld   = bus.a_i;
        opnd_ld = ZERO;
        neg_ld  = 1'b0;
        cnt_ld  = CNT_LAST;
      end else begin
        hi_ld   = ZERO;
        lo_ld   = a_mag;
        opnd_ld = b_mag;
        neg_ld  = op_is_rem(op_in) ? sa : (sa ^ sb);
        cnt_ld  = CNT_ZERO;
      end
    end else begin
      hi_ld   = ZERO;
      lo_ld   = b_mag;
      opnd_ld = a_mag;
      neg_ld  = sa ^ sb;
      cnt_ld  = CNT_ZERO;
    end
  end

  // final-cycle sign fix-up and result selection
  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_q ? (~prod + ONE_P) : prod;
    quo_fix  = neg_q ? (~lo + ONE) : lo;
    rem_fix  = neg_q ? (~hi + ONE) : hi;
    case (op_q)
      MD_MUL:                       result_c = prod_fix[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_c = prod_fix[PW-1:W];
      MD_DIV, MD_DIVU:              result_c = quo_fix;
      MD_REM, MD_REMU:              result_c = rem_fix;
      default:                      result_c = ZERO;
    endcase
  end

  // operand, accumulator, counter and result registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q  <= MD_MUL;
      neg_q <= 1'b0;
      cnt   <= CNT_ZERO;
      hi    <= ZERO;
      lo    <= ZERO;
      opnd  <= ZERO;
      res   <= ZERO;
    end else if (accept) begin
      op_q  <= op_in;
      neg_q <= neg_ld;
      cnt   <= cnt_ld;
      hi    <= hi_ld;
      lo    <= lo_ld;
      opnd  <= opnd_ld;
      res   <= ZERO;
    end else if (step) begin
      hi    <= hi_nx;
      lo    <= lo_nx;
      cnt   <= cnt + CNT_STEP;
    end else if (finish) begin
      res   <= result_c;
    end else if (drop) begin
      res   <= ZERO;
      cnt   <= CNT_ZERO;
    end
  end

  // res is only non-zero while in DONE, so res_o is 0 whenever valid_o is low
  assign bus.ready_o = (state == ST_IDLE);
  assign bus.busy_o  = (state != ST_IDLE);
  assign bus.valid_o = (state == ST_DONE);
  assign bus.res_o   = res;
endmodule
